ahb_apb_bridge_p: RTL and testbench

AHB_APB_BRIDGE_P -- requirements
Module: ahb_apb_bridge_p

---
 rtl/ahb_apb_bridge_p_if.sv | 44 ++++
 rtl/ahb_apb_bridge_p.sv | 176 +++++++++++++++++
 tb/tb_ahb_apb_bridge_p.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_apb_bridge_p_if.sv
// AHB-to-APB bridge bus bundle: AHB slave side plus APB master side.
// The slave modport is the bridge's view; the master modport is the surrounding
// system (AHB master plus APB slaves).
interface ahb_apb_bridge_p_if #(
  parameter int unsigned NUM_SLOTS = 16
);
  // AHB side
  logic                 HSEL;
  logic                 HWRITE;
  logic [31:0]          HADDR;
  logic [31:0]          HWDATA;
  logic                 HREADYIN;
  logic [1:0]           HTRANS;
  logic [2:0]           HSIZE;
  logic [3:0]           HPROT;
  logic [31:0]          HRDATA;
  logic                 HREADYOUT;
  logic                 HRESP;
  // APB side
  logic [NUM_SLOTS-1:0] PSEL;
  logic [31:0]          PADDR;
  logic                 PWRITE;
  logic                 PENABLE;
  logic [31:0]          PWDATA;
  logic [3:0]           PSTRB;
  logic [2:0]           PPROT;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport slave (
    input  HSEL, HWRITE, HADDR, HWDATA, HREADYIN, HTRANS, HSIZE, HPROT,
    output HRDATA, HREADYOUT, HRESP,
    output PSEL, PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HWRITE, HADDR, HWDATA, HREADYIN, HTRANS, HSIZE, HPROT,
    input  HRDATA, HREADYOUT, HRESP,
    input  PSEL, PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahb_apb_bridge_p.sv
// AHB-to-APB bridge with one-hot slot decode from HADDR[SEL_LSB+3:SEL_LSB].
// Illegal slot/size requests take a two-cycle AHB error with no APB activity.
// Optional ACCESS watchdog: define AHB_APB_BRIDGE_TIMEOUT_EN.
module ahb_apb_bridge_p #(
  parameter int unsigned NUM_SLOTS   = 16,
  parameter int unsigned SEL_LSB     = 24,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic               HCLK,
  input logic               HRESET,
  ahb_apb_bridge_p_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StErr1, StErr2} state_e;

  localparam logic [NUM_SLOTS-1:0] SelOne = NUM_SLOTS'(1);

  state_e         state_q, state_d;
  logic [31:0]    paddr_q;
  logic           pwrite_q;
  logic [3:0]     pstrb_q;
  logic [2:0]     pprot_q;
  logic [3:0]     slot_q;
  logic [31:0]    pwdata_q;

  logic [3:0]     slot;
  logic           valid, slot_ok, size_ok, capture, sample;
  logic [3:0]     strb;
  logic [NUM_SLOTS-1:0] psel;
  logic           penable, hreadyout, hresp;
  logic [31:0]    pwdata;

`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
  logic [15:0]    cnt_q, cnt_d;
`else
  localparam int unsigned UnusedTimeoutCyc = TIMEOUT_CYC;
`endif

  logic [1:0] unused_hprot;
  assign unused_hprot = bus.HPROT[3:2];

  assign slot    = bus.HADDR[SEL_LSB+3:SEL_LSB];
  assign valid   = bus.HSEL & bus.HREADYIN & bus.HTRANS[1];
  assign slot_ok = 32'(slot) < NUM_SLOTS;

  // Size/alignment legality and write strobes for the current address phase.
  always_comb begin
    size_ok = 1'b0;
    strb    = 4'b0000;
    case (bus.HSIZE)
      3'd0: begin
        size_ok = 1'b1;
        strb    = 4'b0001 << bus.HADDR[1:0];
      end
      3'd1: begin
        size_ok = ~bus.HADDR[0];
        strb    = 4'b0011 << bus.HADDR[1:0];
      end
      3'd2: begin
        size_ok = (bus.HADDR[1:0] == 2'b00);
        strb    = 4'b1111;
      end
      default: ;
    endcase
    if (!bus.HWRITE) strb = 4'b0000;
  end

  // Next state and per-state bus outputs.
  always_comb begin
    state_d   = state_q;
    psel      = '0;
    penable   = 1'b0;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    pwdata    = pwdata_q;
    capture   = 1'b0;
    sample    = 1'b0;
`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      StIdle: sample = 1'b1;
      StSetup: begin
        psel      = SelOne << slot_q;
        hreadyout = 1'b0;
        pwdata    = bus.HWDATA;
        state_d   = StAccess;
`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      StAccess: begin
        psel      = SelOne << slot_q;
        penable   = 1'b1;
        hreadyout = bus.PREADY & ~bus.PSLVERR;
        if (bus.PREADY) begin
          if (bus.PSLVERR) state_d = StErr1;
          else             sample  = 1'b1;
        end
`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYC)) begin
          // Abandon the stalled slave and report an error to AHB.
          psel    = '0;
          penable = 1'b0;
          state_d = StErr1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      StErr1: begin
        hresp     = 1'b1;
        hreadyout = 1'b0;
        state_d   = StErr2;
      end
      StErr2: begin
        hresp  = 1'b1;
        sample = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    // Address phase may be accepted in IDLE, ERR2 or a completing ACCESS.
    if (sample) begin
      state_d = StIdle;
      if (valid) begin
        if (slot_ok && size_ok) begin
          state_d = StSetup;
          capture = 1'b1;
        end else begin
          state_d = StErr1;
        end
      end
    end
  end

  // State and address-phase/data registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      slot_q   <= '0;
      pwdata_q <= '0;
`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (capture) begin
        paddr_q  <= bus.HADDR;
        pwrite_q <= bus.HWRITE;
        pstrb_q  <= strb;
        pprot_q  <= {~bus.HPROT[0], 1'b0, bus.HPROT[1]};
        slot_q   <= slot;
      end
      if (state_q == StSetup) pwdata_q <= bus.HWDATA;
`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  end

  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.PPROT     = pprot_q;
  assign bus.PWDATA    = pwdata;
  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = bus.PRDATA;

endmodule

// File: tb/tb_ahb_apb_bridge_p.sv
// Directed bench for ahb_apb_bridge_p (4 slots, timeout 8 when the watchdog is built in).
module tb_ahb_apb_bridge_p;

  logic HCLK = 1'b0;
  logic HRESET;
  int   total = 0;
  int   bad   = 0;

  always #5 HCLK = ~HCLK;

  ahb_apb_bridge_p_if #(.NUM_SLOTS(4)) bus ();

  ahb_apb_bridge_p #(
    .NUM_SLOTS  (4),
    .SEL_LSB    (24),
    .TIMEOUT_CYC(8)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_in();
    bus.HSEL    = 1'b0;
    bus.HTRANS  = 2'b00;
    bus.HWRITE  = 1'b0;
    bus.HSIZE   = 3'd0;
    bus.HPROT   = 4'd0;
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b0;
  endtask

  task automatic req(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                     input logic [3:0] prot);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = wr;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
    bus.HPROT  = prot;
  endtask

  initial begin
    HRESET       = 1'b1;
    bus.HREADYIN = 1'b1;
    bus.HADDR    = 32'h0;
    bus.HWDATA   = 32'hDEAD_BEEF;
    bus.PRDATA   = 32'h0;
    idle_in();
    tick();
    tick();
    #1;
    chk("rst_psel", 32'(bus.PSEL), 32'h0);
    chk("rst_penable", 32'(bus.PENABLE), 32'h0);
    chk("rst_pwrite", 32'(bus.PWRITE), 32'h0);
    chk("rst_paddr", bus.PADDR, 32'h0);
    chk("rst_pstrb", 32'(bus.PSTRB), 32'h0);
    chk("rst_pprot", 32'(bus.PPROT), 32'h0);
    chk("rst_pwdata", bus.PWDATA, 32'h0);
    chk("rst_hready", 32'(bus.HREADYOUT), 32'h1);
    chk("rst_hresp", 32'(bus.HRESP), 32'h0);
    HRESET = 1'b0;
    tick();

    // BUSY transfer is ignored in IDLE.
    bus.HSEL = 1'b1; bus.HTRANS = 2'b01; bus.HADDR = 32'h0100_0000;
    tick();
    #1;
    chk("busy_psel", 32'(bus.PSEL), 32'h0);
    chk("busy_hready", 32'(bus.HREADYOUT), 32'h1);

    // Word write, zero wait.
    req(1'b1, 32'h0300_0010, 3'd2, 4'b0011);
    #1;
    chk("w_n_hready", 32'(bus.HREADYOUT), 32'h1);
    tick();
    idle_in();
    bus.HWDATA = 32'hA5A5_5A5A;
    #1;
    chk("w_setup_psel", 32'(bus.PSEL), 32'h8);
    chk("w_setup_penable", 32'(bus.PENABLE), 32'h0);
    chk("w_setup_hready", 32'(bus.HREADYOUT), 32'h0);
    chk("w_setup_pwdata", bus.PWDATA, 32'hA5A5_5A5A);
    chk("w_setup_paddr", bus.PADDR, 32'h0300_0010);
    chk("w_setup_pwrite", 32'(bus.PWRITE), 32'h1);
    chk("w_setup_pprot", 32'(bus.PPROT), 32'h1);
    tick();
    bus.HWDATA = 32'h0;
    #1;
    chk("w_acc_psel", 32'(bus.PSEL), 32'h8);
    chk("w_acc_penable", 32'(bus.PENABLE), 32'h1);
    chk("w_acc_pstrb", 32'(bus.PSTRB), 32'hF);
    chk("w_acc_pwdata", bus.PWDATA, 32'hA5A5_5A5A);
    chk("w_acc_hready", 32'(bus.HREADYOUT), 32'h1);
    tick();
    #1;
    chk("w_done_psel", 32'(bus.PSEL), 32'h0);

    // Byte read with three wait states.
    req(1'b0, 32'h0100_0003, 3'd0, 4'b0000);
    tick();
    idle_in();
    bus.PREADY = 1'b0;
    #1;
    chk("r_setup_psel", 32'(bus.PSEL), 32'h2);
    chk("r_setup_pstrb", 32'(bus.PSTRB), 32'h0);
    chk("r_setup_pprot", 32'(bus.PPROT), 32'h4);
    chk("r_setup_hready", 32'(bus.HREADYOUT), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("r_wait_hready", 32'(bus.HREADYOUT), 32'h0);
      chk("r_wait_penable", 32'(bus.PENABLE), 32'h1);
    end
    tick();
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h1234_5678;
    #1;
    chk("r_done_hready", 32'(bus.HREADYOUT), 32'h1);
    chk("r_done_hrdata", bus.HRDATA, 32'h1234_5678);
    tick();

    // Halfword write strobes.
    req(1'b1, 32'h0000_0002, 3'd1, 4'b0001);
    tick();
    idle_in();
    #1;
    chk("hw_pstrb", 32'(bus.PSTRB), 32'hC);
    chk("hw_pprot", 32'(bus.PPROT), 32'h0);
    tick();
    tick();

    // Misaligned word, then out-of-range slot: two-cycle error, no PSEL.
    for (int k = 0; k < 2; k++) begin
      if (k == 0) req(1'b1, 32'h0000_0002, 3'd2, 4'b0000);
      else        req(1'b0, 32'h0500_0000, 3'd2, 4'b0000);
      tick();
      idle_in();
      #1;
      chk("err1_psel", 32'(bus.PSEL), 32'h0);
      chk("err1_hresp", 32'(bus.HRESP), 32'h1);
      chk("err1_hready", 32'(bus.HREADYOUT), 32'h0);
      tick();
      #1;
      chk("err2_psel", 32'(bus.PSEL), 32'h0);
      chk("err2_hresp", 32'(bus.HRESP), 32'h1);
      chk("err2_hready", 32'(bus.HREADYOUT), 32'h1);
      tick();
      #1;
      chk("err_idle_hresp", 32'(bus.HRESP), 32'h0);
    end

    // Slave error.
    req(1'b1, 32'h0200_0000, 3'd2, 4'b0000);
    tick();
    idle_in();
    tick();
    bus.PSLVERR = 1'b1;
    #1;
    chk("slverr_hready", 32'(bus.HREADYOUT), 32'h0);
    tick();
    bus.PSLVERR = 1'b0;
    #1;
    chk("slverr_e1_hresp", 32'(bus.HRESP), 32'h1);
    chk("slverr_e1_hready", 32'(bus.HREADYOUT), 32'h0);
    chk("slverr_e1_psel", 32'(bus.PSEL), 32'h0);
    tick();
    #1;
    chk("slverr_e2_hresp", 32'(bus.HRESP), 32'h1);
    chk("slverr_e2_hready", 32'(bus.HREADYOUT), 32'h1);
    tick();

    // Back-to-back write then read.
    req(1'b1, 32'h0000_0004, 3'd2, 4'b0000);
    tick();
    idle_in();
    bus.HWDATA = 32'h1111_2222;
    tick();
    req(1'b0, 32'h0100_0008, 3'd2, 4'b0000);
    #1;
    chk("b2b_acc1_psel", 32'(bus.PSEL), 32'h1);
    chk("b2b_acc1_hready", 32'(bus.HREADYOUT), 32'h1);
    tick();
    idle_in();
    #1;
    chk("b2b_setup2_psel", 32'(bus.PSEL), 32'h2);
    chk("b2b_setup2_penable", 32'(bus.PENABLE), 32'h0);
    chk("b2b_setup2_pwrite", 32'(bus.PWRITE), 32'h0);
    chk("b2b_setup2_paddr", bus.PADDR, 32'h0100_0008);
    tick();
    bus.PRDATA = 32'hCAFE_F00D;
    #1;
    chk("b2b_acc2_hrdata", bus.HRDATA, 32'hCAFE_F00D);
    chk("b2b_acc2_hready", 32'(bus.HREADYOUT), 32'h1);
    tick();

    // Stalled slave.
    req(1'b1, 32'h0000_0000, 3'd2, 4'b0000);
    tick();
    idle_in();
    bus.PREADY = 1'b0;
`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      tick();
      #1;
      chk("to_wait_psel", 32'(bus.PSEL), 32'h1);
    end
    tick();
    #1;
    chk("to_drop_psel", 32'(bus.PSEL), 32'h0);
    chk("to_drop_penable", 32'(bus.PENABLE), 32'h0);
    tick();
    #1;
    chk("to_e1_hresp", 32'(bus.HRESP), 32'h1);
    chk("to_e1_hready", 32'(bus.HREADYOUT), 32'h0);
    tick();
    #1;
    chk("to_e2_hresp", 32'(bus.HRESP), 32'h1);
    chk("to_e2_hready", 32'(bus.HREADYOUT), 32'h1);
    tick();
    req(1'b1, 32'h0000_0000, 3'd2, 4'b0000);
    tick();
    idle_in();
    bus.PREADY = 1'b0;
    tick();
`else
    for (int i = 0; i < 20; i++) tick();
    #1;
    chk("stall_psel", 32'(bus.PSEL), 32'h1);
    chk("stall_penable", 32'(bus.PENABLE), 32'h1);
`endif
    // Reset during ACCESS.
    chk("rst_acc_before", 32'(bus.PENABLE), 32'h1);
    HRESET = 1'b1;
    tick();
    #1;
    chk("rst_acc_psel", 32'(bus.PSEL), 32'h0);
    chk("rst_acc_penable", 32'(bus.PENABLE), 32'h0);
    chk("rst_acc_hready", 32'(bus.HREADYOUT), 32'h1);
    HRESET = 1'b0;
    bus.PREADY = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
